// File: rtl/wind_pkg.sv
// ============================================================================
//  Module      : wind_pkg
//  Description : Shared types and constants for the wind controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wind_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        ANIM = 2'd2,
        DONE = 2'd3
    } wind_state_t;

    localparam int          WIND_MAX   = 7;
    localparam int          BAR_HALF_W = 58;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Nibble 15 maps to calm; 0..14 map onto -7..+7.
    function automatic logic signed [3:0] wind_from_rand(input logic [3:0] r);
        logic signed [3:0] w;
        if (r == 4'hF) begin
            w = 4'sd0;
        end else begin
            w = r - 4'd7;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wind_lfsr.sv
// ============================================================================
//  Module      : wind_lfsr
//  Description : Free-running 16-bit Galois LFSR, advances every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wind_lfsr
    import wind_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/wind_ctl.sv
// ============================================================================
//  Module      : wind_ctl
//  Description : Picks a random wind per turn and steers the wind-bar
//                indicator; WIND_ANIM_EN enables per-frame animation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wind_ctl
    import wind_pkg::*;
#(
    parameter int STEP_PX     = 2,
    parameter int PX_PER_UNIT = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblnk,
    input  logic              new_turn,
    output logic              busy,
    output logic              ready,
    output logic signed [3:0] wind,
    output logic signed [6:0] bar_offset
);

    wind_state_t       state_q, state_d;
    logic signed [3:0] wind_q, wind_d;
    logic signed [6:0] target_q, target_d;
    logic signed [6:0] bar_offset_q, bar_offset_d;

    logic [15:0]       lfsr_value;
    logic signed [3:0] w_wind_new;
    logic signed [6:0] w_target_new;
    logic              unused_lfsr_hi;

    wind_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_value)
    );

    assign unused_lfsr_hi = ^lfsr_value[15:4];
    assign w_wind_new     = wind_from_rand(lfsr_value[3:0]);
    // |wind| * PX_PER_UNIT stays within the bar half-width, so 7 bits suffice.
    assign w_target_new   = {{3{w_wind_new[3]}}, w_wind_new} * 7'(PX_PER_UNIT);

`ifdef WIND_ANIM_EN
    localparam logic signed [7:0] C_STEP = 8'(STEP_PX);

    logic              vblnk_q;
    logic              w_tick;
    logic signed [7:0] w_diff;
    logic signed [6:0] w_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
        end
    end

    assign w_tick = vblnk & ~vblnk_q;
    assign w_diff = {target_q[6], target_q} - {bar_offset_q[6], bar_offset_q};

    // Last step lands exactly on the target instead of overshooting it.
    always_comb begin
        if (w_diff > C_STEP) begin
            w_step = bar_offset_q + 7'(STEP_PX);
        end else if (w_diff < -C_STEP) begin
            w_step = bar_offset_q - 7'(STEP_PX);
        end else begin
            w_step = target_q;
        end
    end
`else
    logic unused_vblnk;
    assign unused_vblnk = vblnk;
`endif

    always_comb begin
        state_d      = state_q;
        wind_d       = wind_q;
        target_d     = target_q;
        bar_offset_d = bar_offset_q;
        case (state_q)
            IDLE: begin
                if (new_turn) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                wind_d   = w_wind_new;
                target_d = w_target_new;
`ifdef WIND_ANIM_EN
                state_d  = ANIM;
`else
                bar_offset_d = w_target_new;
                state_d      = DONE;
`endif
            end
            ANIM: begin
`ifdef WIND_ANIM_EN
                if (bar_offset_q == target_q) begin
                    state_d = DONE;
                end else if (w_tick) begin
                    bar_offset_d = w_step;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wind_q       <= 4'sd0;
            target_q     <= 7'sd0;
            bar_offset_q <= 7'sd0;
        end else begin
            state_q      <= state_d;
            wind_q       <= wind_d;
            target_q     <= target_d;
            bar_offset_q <= bar_offset_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign ready      = (state_q == DONE);
    assign wind       = wind_q;
    assign bar_offset = bar_offset_q;

endmodule

`default_nettype wire

// File: doc/wind_ctl.md
WIND_CTL -- requirements
Module: wind_ctl

Interface
REQ-001 The module SHALL have parameter STEP_PX, default 2, meaning the indicator pixels moved per frame during animation (1..8).
REQ-002 The module SHALL have parameter PX_PER_UNIT, default 8, meaning the indicator pixels per wind unit; PX_PER_UNIT*7 SHALL NOT exceed 58 (half inner bar width).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The module SHALL have port vblnk, input, 1 bit: the vertical blank from the VGA timing chain; its rising edge is the frame tick.
REQ-006 The module SHALL have port new_turn, input, 1 bit: a request for a new wind value; it is sampled every cycle.
REQ-007 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The module SHALL have port ready, output, 1 bit: a one-cycle pulse when the wind value and indicator have settled.
REQ-009 The module SHALL have port wind, output, signed 4 bits: the current wind, -7..+7.
REQ-010 The module SHALL have port bar_offset, output, signed 7 bits: the indicator offset from the bar centre in pixels, consumed by the wind bar drawing stage.

Function
REQ-011 The module SHALL contain a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 and seed 16'hACE1, advancing every clock regardless of state.
REQ-012 The module SHALL implement a state machine with states IDLE, PICK, ANIM and DONE.
REQ-013 In IDLE with new_turn=1, the next state SHALL be PICK; new_turn SHALL be ignored in every other state, including the cycle in which DONE returns to IDLE.
REQ-014 PICK SHALL last one cycle: r=lfsr[3:0]; wind <= (r==15) ? 0 : r-7; target <= wind_new*PX_PER_UNIT (signed, no overflow); next state ANIM.
REQ-015 vblnk SHALL be registered once and a frame tick generated as vblnk & ~vblnk_q.
REQ-016 In ANIM, on each frame tick bar_offset SHALL move toward target by STEP_PX, clamped so it never overshoots; bar_offset SHALL NOT change between ticks.
REQ-017 In ANIM, when bar_offset==target (including on entry), the next state SHALL be DONE.
REQ-018 DONE SHALL last one cycle with ready=1, then the next state SHALL be IDLE; ready SHALL be 0 in all other states.
REQ-019 wind and bar_offset SHALL hold their values in IDLE between turns.

Reset
REQ-020 While rst_n=0: state=IDLE, lfsr=16'hACE1, vblnk_q=0, wind=0, bar_offset=0, target=0, busy=0, ready=0.
REQ-021 Reset asserted mid-animation SHALL abort immediately to the reset values; after reset release, no ready pulse SHALL occur until a new request.

Configuration
REQ-022 With WIND_ANIM_EN defined, the module SHALL behave per REQ-016/017.
REQ-023 Without WIND_ANIM_EN, PICK SHALL also load bar_offset <= target and go directly to DONE; ready SHALL be high exactly 2 cycles after new_turn is sampled; vblnk SHALL be unused.

Structure
REQ-024 The state enum wind_state_t, WIND_MAX=7, and BAR_HALF_W=58 SHALL reside in the shared package wind_pkg.
REQ-025 The LFSR SHALL be a sub-module named wind_lfsr (ports clk, rst_n, value[15:0]).
REQ-026 The FSM, frame-edge detection and offset stepping SHALL reside in wind_ctl.

Verification
REQ-027 Reset: hold rst_n=0 for 5 cycles -> all outputs 0, busy=0; release -> outputs unchanged with no request.
REQ-028 Force lfsr[3:0]=4'hE at PICK, STEP_PX=2 -> wind=+7, bar_offset steps 0,2,...,56 over 28 vblnk edges, one ready pulse, then busy=0.
REQ-029 From bar_offset=56, force r=4'h0 -> wind=-7, 56 ticks down to -56; force r=4'hF -> wind=0 and offset returns to 0.
REQ-030 STEP_PX=3, target 8 from 0 -> offsets 3,6,8 (clamped), ready on the following cycle.
REQ-031 new_turn pulses during ANIM and in the DONE cycle -> ignored, exactly one ready; new_turn in the next IDLE cycle -> accepted.
REQ-032 rst_n low mid-ANIM -> immediate zero outputs; build without WIND_ANIM_EN -> ready 2 cycles after new_turn with bar_offset=target.
